mem_access_unit: RTL and testbench

Load/store initiator for the MEM stage of the MIPS pipeline. It accepts one byte-addressed load or store request per transaction from the EX/MEM latch and drives the word-addressed data memory port. Loads extract a byte or halfword lane, then sign- or zero-extend it. Byte and halfword stores are read-modify-write, so neighbouring lanes are preserved. It stalls the pipeline while a transaction is in flight.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_access_unit_if.sv | 72 +++++++
 rtl/mem_lane_align.sv | 45 ++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store initiator: size codes,
// FSM state encoding and the latched request control bundle.
package mem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_WR     = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef struct packed {
        logic [1:0] size;
        logic       sgn;
        logic       store;
        logic       misal;
    } req_ctl_t;

    // Byte and halfword stores must read the old word first.
    function automatic logic is_partial(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

    // Any size code other than byte/half behaves as a word.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b0;
        if (size == SIZE_HALF) begin
            bad = lo[0];
        end else if (size != SIZE_BYTE) begin
            bad = (lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bundle of the MEM-stage unit.
// slave = the unit itself, master = pipeline plus memory side.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);

    logic                  i_valid;
    logic                  o_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_load;
    logic                  i_store;
    logic                  i_signed;
    logic [1:0]            i_size;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_done;
    logic                  o_stall;
    logic [DATA_WIDTH-1:0] o_mem_address;
    logic [DATA_WIDTH-1:0] o_mem_datawrite;
    logic                  o_mem_memread;
    logic                  o_mem_memwrite;
    logic                  o_mem_signed;
    logic [1:0]            o_mem_size;
    logic [DATA_WIDTH-1:0] i_mem_dataread;
    logic                  o_misaligned;

    modport slave (
        input  i_valid,
        input  i_addr,
        input  i_wdata,
        input  i_load,
        input  i_store,
        input  i_signed,
        input  i_size,
        input  i_mem_dataread,
        output o_ready,
        output o_rdata,
        output o_done,
        output o_stall,
        output o_mem_address,
        output o_mem_datawrite,
        output o_mem_memread,
        output o_mem_memwrite,
        output o_mem_signed,
        output o_mem_size,
        output o_misaligned
    );

    modport master (
        output i_valid,
        output i_addr,
        output i_wdata,
        output i_load,
        output i_store,
        output i_signed,
        output i_size,
        output i_mem_dataread,
        input  o_ready,
        input  o_rdata,
        input  o_done,
        input  o_stall,
        input  o_mem_address,
        input  o_mem_datawrite,
        input  o_mem_memread,
        input  o_mem_memwrite,
        input  o_mem_signed,
        input  o_mem_size,
        input  o_misaligned
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends a load lane and
// merges store data into the old word for read-modify-write.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  byte_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sh  = {i_lo, 3'b000};
        byte_sel = i_word[byte_sh +: 8];
        half_sel = i_lo[1] ? i_word[31:16] : i_word[15:0];
        o_load   = i_word;
        o_merged = i_data;
        unique case (1'b1)
            (i_size == SIZE_BYTE): begin
                o_load = {{24{i_signed & byte_sel[7]}}, byte_sel};
                o_merged = i_word;
                o_merged[byte_sh +: 8] = i_data[7:0];
            end
            (i_size == SIZE_HALF): begin
                o_load = {{16{i_signed & half_sel[15]}}, half_sel};
                o_merged = i_word;
                if (i_lo[1]) begin
                    o_merged[31:16] = i_data[15:0];
                end else begin
                    o_merged[15:0] = i_data[15:0];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving a word-addressed memory.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word requests fault.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic              i_clock,
    input logic              i_reset,
    mem_access_unit_if.slave bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    req_ctl_t              ctl_q, ctl_d;

    logic                  req_go;
    logic                  accept;
    logic                  req_misal;
    logic [31:0]           load_val;
    logic [31:0]           merged;

    assign req_go = bus.i_valid && (bus.i_load || bus.i_store);
    assign accept = req_go && (state_q == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    assign req_misal = is_misaligned(bus.i_size, bus.i_addr[1:0]);
`else
    assign req_misal = 1'b0;
`endif

    mem_lane_align u_lane (
        .i_word   (word_q),
        .i_data   (wdata_q),
        .i_lo     (addr_q[1:0]),
        .i_size   (ctl_q.size),
        .i_signed (ctl_q.sgn),
        .o_load   (load_val),
        .o_merged (merged)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            ctl_q   <= ctl_d;
        end
    end

    // Request fields are held for the whole transaction.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctl_d   = ctl_q;
        word_d  = word_q;
        if (accept) begin
            addr_d      = bus.i_addr;
            wdata_d     = bus.i_wdata;
            ctl_d.size  = bus.i_size;
            ctl_d.sgn   = bus.i_signed;
            ctl_d.store = bus.i_store;
            ctl_d.misal = req_misal;
        end
        if ((state_q == ST_RD) || (state_q == ST_RMW_RD)) begin
            word_d = bus.i_mem_dataread;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_misal) begin
                        state_d = ST_DONE;
                    end else if (bus.i_store) begin
                        state_d = is_partial(bus.i_size)
                                ? ST_RMW_RD : ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:     state_d = ST_DONE;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_DONE;
            ST_WR:     state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready         = (state_q == ST_IDLE);
        bus.o_stall         = 1'b0;
        bus.o_done          = 1'b0;
        bus.o_rdata         = '0;
        bus.o_mem_memread   = 1'b0;
        bus.o_mem_memwrite  = 1'b0;
        bus.o_mem_datawrite = '0;
        bus.o_misaligned    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.o_stall = req_go;
            end
            ST_RD, ST_RMW_RD: begin
                bus.o_stall       = 1'b1;
                bus.o_mem_memread = 1'b1;
            end
            ST_RMW_WR: begin
                bus.o_stall         = 1'b1;
                bus.o_mem_memwrite  = 1'b1;
                bus.o_mem_datawrite = merged;
            end
            ST_WR: begin
                bus.o_stall         = 1'b1;
                bus.o_mem_memwrite  = 1'b1;
                bus.o_mem_datawrite = wdata_q;
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
                if (!ctl_q.store && !ctl_q.misal) begin
                    bus.o_rdata = load_val;
                end
`ifdef MEM_ALIGN_CHECK_EN
                bus.o_misaligned = ctl_q.misal;
`endif
            end
            default: begin
            end
        endcase
    end

    assign bus.o_mem_address = DATA_WIDTH'(addr_q >> 2);
    assign bus.o_mem_signed  = 1'b0;
    assign bus.o_mem_size    = 2'b00;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences and
// random transactions against a word-array reference model.
module tb_mem_access_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];

    assign bus.i_mem_dataread = mem[bus.o_mem_address[3:0]];

    always @(posedge clk) begin
        if (bus.o_mem_memwrite) begin
            mem[bus.o_mem_address[3:0]] <= bus.o_mem_datawrite;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          ld;
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] exp_rdata;
        int          exp_done;
        int          exp_nrd;
        int          exp_nwr;
        logic [31:0] exp_wword;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit model_misal(input logic [1:0] sz,
                                       input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        if (sz == 2'b01) return 1'b0;
        if (sz == 2'b10) return a[0];
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w,
        input logic [31:0] a, input logic [1:0] sz, input bit sg);
        logic [31:0] v;
        if (sz == 2'b01) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b10) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w,
        input logic [31:0] d, input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] mask;
        int          sh;
        if (sz == 2'b01) begin
            sh = 8 * a[1:0];
            mask = 32'hFF << sh;
        end else if (sz == 2'b10) begin
            sh = 16 * a[1];
            mask = 32'hFFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic run_req(input bit ld, input bit st,
        input logic [31:0] a, input logic [31:0] wd,
        input logic [1:0] sz, input bit sg,
        output logic [31:0] rd, output int dc, output int nrd,
        output int nwr, output logic [31:0] wword,
        output logic [31:0] saddr, output bit mis, output bit sbad);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_load   = ld;
        bus.i_store  = st;
        bus.i_addr   = a;
        bus.i_wdata  = wd;
        bus.i_size   = sz;
        bus.i_signed = sg;
        #1;
        sbad  = (bus.o_stall !== 1'b1) || (bus.o_ready !== 1'b1);
        rd    = 'x;
        wword = 'x;
        saddr = 'x;
        mis   = 1'b0;
        dc    = -1;
        nrd   = 0;
        nwr   = 0;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_load  = 1'b0;
        bus.i_store = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.o_mem_memread && bus.o_mem_memwrite) sbad = 1'b1;
            if (bus.o_mem_memread) begin
                nrd++;
                saddr = bus.o_mem_address;
            end
            if (bus.o_mem_memwrite) begin
                nwr++;
                wword = bus.o_mem_datawrite;
                saddr = bus.o_mem_address;
            end
            if (bus.o_done) begin
                dc  = k;
                rd  = bus.o_rdata;
                mis = bus.o_misaligned;
                if (bus.o_stall) sbad = 1'b1;
                break;
            end else if (!bus.o_stall) begin
                sbad = 1'b1;
            end
        end
    endtask

    task automatic expect_txn(input string nm, input bit ld, input bit st,
        input logic [31:0] a, input logic [31:0] wd,
        input logic [1:0] sz, input bit sg,
        input logic [31:0] e_rd, input int e_dc, input int e_nrd,
        input int e_nwr, input logic [31:0] e_ww, input bit e_mis);
        logic [31:0] rd, wword, saddr;
        int          dc, nrd, nwr;
        bit          mis, sbad;
        run_req(ld, st, a, wd, sz, sg, rd, dc, nrd, nwr,
                wword, saddr, mis, sbad);
        chk({nm, ".done_cycle"}, dc, e_dc);
        chk({nm, ".memreads"}, nrd, e_nrd);
        chk({nm, ".memwrites"}, nwr, e_nwr);
        chk({nm, ".rdata"}, rd, e_rd);
        chk({nm, ".misaligned"}, {31'd0, mis}, {31'd0, e_mis});
        chk({nm, ".stall"}, {31'd0, sbad}, 32'd0);
        if (e_nwr > 0) chk({nm, ".wword"}, wword, e_ww);
        if (e_nrd + e_nwr > 0) chk({nm, ".index"}, saddr, a >> 2);
    endtask

    vec_t vecs [$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_load   = 1'b0;
        bus.i_store  = 1'b0;
        bus.i_addr   = '0;
        bus.i_wdata  = '0;
        bus.i_size   = '0;
        bus.i_signed = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h1111_1111 * i;
            ref_mem[i] = 32'h1111_1111 * i;
        end
        mem[1]     = 32'h8899_AABB;
        ref_mem[1] = 32'h8899_AABB;

        vecs.push_back('{"ldb_s_6", 1, 0, 32'h6, 0, 2'b01, 1,
                         32'hFFFF_FF99, 2, 1, 0, 0});
        vecs.push_back('{"ldb_u_4", 1, 0, 32'h4, 0, 2'b01, 0,
                         32'h0000_00BB, 2, 1, 0, 0});
        vecs.push_back('{"sth_6", 0, 1, 32'h6, 32'h0000_1234, 2'b10, 0,
                         0, 3, 1, 1, 32'h1234_AABB});
        vecs.push_back('{"stw_8", 0, 1, 32'h8, 32'hDEAD_BEEF, 2'b00, 0,
                         0, 2, 0, 1, 32'hDEAD_BEEF});
        vecs.push_back('{"ldh_s_4", 1, 0, 32'h4, 0, 2'b10, 1,
                         32'hFFFF_AABB, 2, 1, 0, 0});
        vecs.push_back('{"ldh_u_6", 1, 0, 32'h6, 0, 2'b10, 0,
                         32'h0000_1234, 2, 1, 0, 0});
        vecs.push_back('{"ldb_s_9", 1, 0, 32'h9, 0, 2'b01, 1,
                         32'hFFFF_FFBE, 2, 1, 0, 0});
        vecs.push_back('{"ld_sz3_8", 1, 0, 32'h8, 0, 2'b11, 1,
                         32'hDEAD_BEEF, 2, 1, 0, 0});
        vecs.push_back('{"stb_b", 0, 1, 32'hB, 32'hFFFF_FF77, 2'b01, 0,
                         0, 3, 1, 1, 32'h77AD_BEEF});
        vecs.push_back('{"ldw_8", 1, 0, 32'h8, 0, 2'b00, 0,
                         32'h77AD_BEEF, 2, 1, 0, 0});
        vecs.push_back('{"ldst_c", 1, 1, 32'hC, 32'hCAFE_F00D, 2'b00, 0,
                         0, 2, 0, 1, 32'hCAFE_F00D});
        vecs.push_back('{"ldw_c", 1, 0, 32'hC, 0, 2'b00, 1,
                         32'hCAFE_F00D, 2, 1, 0, 0});

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset.ready", {31'd0, bus.o_ready}, 32'd1);
        chk("reset.ctl", {27'd0, bus.o_stall, bus.o_done,
            bus.o_mem_memread, bus.o_mem_memwrite, bus.o_misaligned},
            32'd0);
        chk("reset.rdata", bus.o_rdata, 32'd0);
        chk("reset.mem_bus", bus.o_mem_address | bus.o_mem_datawrite |
            {29'd0, bus.o_mem_signed, bus.o_mem_size}, 32'd0);

        foreach (vecs[i]) begin
            expect_txn(vecs[i].name, vecs[i].ld, vecs[i].st, vecs[i].addr,
                vecs[i].wdata, vecs[i].size, vecs[i].sgn, vecs[i].exp_rdata,
                vecs[i].exp_done, vecs[i].exp_nrd, vecs[i].exp_nwr,
                vecs[i].exp_wword, 1'b0);
            if (vecs[i].st) ref_mem[vecs[i].addr >> 2] = vecs[i].exp_wword;
        end

        // Valid without an operation must be ignored.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h4;
        #1 chk("noop.stall", {31'd0, bus.o_stall}, 32'd0);
        begin
            int strobes;
            strobes = 0;
            repeat (3) begin
                @(negedge clk);
                strobes += int'(bus.o_mem_memread) + int'(bus.o_mem_memwrite)
                         + int'(bus.o_done);
            end
            chk("noop.strobes", strobes, 0);
            chk("noop.ready", {31'd0, bus.o_ready}, 32'd1);
        end
        bus.i_valid = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
        expect_txn("misal_ldh_5", 1, 0, 32'h5, 0, 2'b10, 0,
                   32'd0, 1, 0, 0, 0, 1'b1);
        expect_txn("misal_stw_9", 0, 1, 32'h9, 32'h5555_5555, 2'b00, 0,
                   32'd0, 1, 0, 0, 0, 1'b1);
        chk("misal_stw_9.mem", mem[2], ref_mem[2]);
`else
        expect_txn("ldh_u_5", 1, 0, 32'h5, 0, 2'b10, 0,
                   32'h0000_AABB, 2, 1, 0, 0, 1'b0);
        expect_txn("ldw_7", 1, 0, 32'h7, 0, 2'b00, 0,
                   32'h1234_AABB, 2, 1, 0, 0, 1'b0);
`endif

        // Reset while the RMW read is on the bus.
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_store  = 1'b1;
        bus.i_addr   = 32'h4;
        bus.i_wdata  = 32'h0000_0055;
        bus.i_size   = 2'b01;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_store = 1'b0;
        @(negedge clk);
        chk("rst_mid.memread", {31'd0, bus.o_mem_memread}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.ready", {31'd0, bus.o_ready}, 32'd1);
        begin
            int late;
            late = int'(bus.o_mem_memwrite) + int'(bus.o_done);
            repeat (3) begin
                @(negedge clk);
                late += int'(bus.o_mem_memwrite) + int'(bus.o_done);
            end
            chk("rst_mid.late_activity", late, 0);
        end
        chk("rst_mid.mem1", mem[1], ref_mem[1]);

        for (int t = 0; t < 60; t++) begin
            bit          ld, st, sg, mis;
            logic [31:0] a, wd, e_rd, e_ww;
            logic [1:0]  sz;
            int          op, idx, e_dc, e_nrd, e_nwr;
            op  = $urandom_range(0, 2);
            ld  = (op != 1);
            st  = (op != 0);
            a   = $urandom_range(0, 63);
            wd  = $urandom;
            sz  = 2'($urandom_range(0, 3));
            sg  = 1'($urandom_range(0, 1));
            idx = a >> 2;
            mis = model_misal(sz, a);
            e_rd = 32'd0;
            e_ww = 32'd0;
            if (mis) begin
                e_dc = 1; e_nrd = 0; e_nwr = 0;
            end else if (st) begin
                e_ww  = model_store(ref_mem[idx], wd, a, sz);
                e_nwr = 1;
                e_nrd = (sz == 2'b01 || sz == 2'b10) ? 1 : 0;
                e_dc  = 2 + e_nrd;
            end else begin
                e_rd  = model_load(ref_mem[idx], a, sz, sg);
                e_nrd = 1; e_nwr = 0; e_dc = 2;
            end
            expect_txn($sformatf("rnd%0d", t), ld, st, a, wd, sz, sg,
                       e_rd, e_dc, e_nrd, e_nwr, e_ww, mis);
            if (st && !mis) ref_mem[idx] = e_ww;
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final.mem%0d", i), mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
